// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller with lane steering, load extension and busywait timeout
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ_EN,
  input  logic        MEM_WRITE_EN,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WRITE_DATA,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WRITEDATA,
  output logic [3:0]  DMEM_BYTEEN,
  input  logic [31:0] DMEM_READDATA,
  input  logic        DMEM_BUSYWAIT,
  output logic        MEM_BUSYWAIT,
  output logic [31:0] LOAD_DATA,
  output logic        MISALIGNED,
  output logic        MEM_ERROR
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [31:0] cnt;
  logic        req, is_byte, is_half, is_word, start, timeout;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext, wdata;
  logic [3:0]  ben;
  assign req          = MEM_READ_EN | MEM_WRITE_EN;
  assign is_byte      = FUNC3[1:0] == 2'b00;
  assign is_half      = FUNC3[1:0] == 2'b01;
  assign is_word      = !is_byte && !is_half;
  assign MISALIGNED   = req && ((is_half && ADDR[0]) || (is_word && ADDR[1:0] != 2'b00));
  assign start        = state == IDLE && req && !MISALIGNED;
  assign MEM_BUSYWAIT = start || state == ACCESS;
  assign timeout      = MAX_WAIT != 0 && cnt + 32'd1 == 32'(MAX_WAIT);
  // Extraction uses the offset/size captured at issue, not the live inputs
  always_comb begin
    lb    = DMEM_READDATA[{off, 3'b000} +: 8];
    lh    = off[1] ? DMEM_READDATA[31:16] : DMEM_READDATA[15:0];
    ext   = f3[1:0] == 2'b00 ? {{24{lb[7] & !f3[2]}}, lb} :
            f3[1:0] == 2'b01 ? {{16{lh[15] & !f3[2]}}, lh} : DMEM_READDATA;
    wdata = is_byte ? {4{WRITE_DATA[7:0]}} : is_half ? {2{WRITE_DATA[15:0]}} : WRITE_DATA;
    ben   = (!MEM_WRITE_EN || is_word) ? 4'b1111 :
            is_byte ? 4'b0001 << ADDR[1:0] : ADDR[1] ? 4'b1100 : 4'b0011;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      DMEM_READ      <= 1'b0;
      DMEM_WRITE     <= 1'b0;
      DMEM_ADDR      <= '0;
      DMEM_WRITEDATA <= '0;
      DMEM_BYTEEN    <= '0;
      LOAD_DATA      <= '0;
      MEM_ERROR      <= 1'b0;
      cnt            <= '0;
      f3             <= '0;
      off            <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          DMEM_READ      <= !MEM_WRITE_EN;
          DMEM_WRITE     <= MEM_WRITE_EN;
          DMEM_ADDR      <= {ADDR[31:2], 2'b00};
          DMEM_WRITEDATA <= wdata;
          DMEM_BYTEEN    <= ben;
          f3             <= FUNC3;
          off            <= ADDR[1:0];
          cnt            <= '0;
          state          <= ACCESS;
        end
        ACCESS: if (!DMEM_BUSYWAIT) begin
          if (DMEM_READ) LOAD_DATA <= ext;
          DMEM_READ  <= 1'b0;
          DMEM_WRITE <= 1'b0;
          state      <= DONE;
        end else if (timeout) begin
          DMEM_READ  <= 1'b0;
          DMEM_WRITE <= 1'b0;
          LOAD_DATA  <= '0;
          MEM_ERROR  <= 1'b1;
          state      <= DONE;
        end else begin
          cnt <= cnt + 32'd1;
        end
        DONE: begin
          MEM_ERROR <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller sitting directly downstream of the EX/MEM pipeline register; it consumes that register's memory-control outputs.
- Translates byte-addressed RV32 loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned data-memory requests with byte enables, and waits out the memory handshake.
- Holds the pipeline via MEM_BUSYWAIT while an access is outstanding, then delivers aligned, sign- or zero-extended load data to the MEM/WB path.

Parameters:
MAX_WAIT, 255, maximum ACCESS cycles with DMEM_BUSYWAIT high before the access is aborted; 0 disables the timeout.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RESET  in  1  reset, synchronous, active-high.
MEM_READ_EN  in  1  load request from EX/MEM.
MEM_WRITE_EN  in  1  store request from EX/MEM.
FUNC3  in  3  access size and signedness, from EX/MEM.
ADDR  in  32  byte address (EX/MEM result).
WRITE_DATA  in  32  store source (EX/MEM register data 2).
DMEM_READ  out  1  registered memory read strobe.
DMEM_WRITE  out  1  registered memory write strobe.
DMEM_ADDR  out  32  word address {ADDR[31:2],2'b00}, registered.
DMEM_WRITEDATA  out  32  lane-replicated store data, registered.
DMEM_BYTEEN  out  4  byte-lane enables, registered.
DMEM_READDATA  in  32  memory read word.
DMEM_BUSYWAIT  in  1  high while memory is busy.
MEM_BUSYWAIT  out  1  stall to all pipeline registers (combinational).
LOAD_DATA  out  32  extended load result, registered.
MISALIGNED  out  1  combinational misalignment flag for the current request.
MEM_ERROR  out  1  registered; high for the DONE cycle of a timed-out access.

Behaviour:
- Reset: on a rising edge with RESET=1, state goes to IDLE and every registered output (DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA, DMEM_BYTEEN, LOAD_DATA, MEM_ERROR) and the wait counter clear to 0. This also aborts any access in progress.
- Request: req = MEM_READ_EN | MEM_WRITE_EN. If both are high, the access is a write.
- Size decode:
  - 000 byte signed; 100 byte unsigned.
  - 001 half signed; 101 half unsigned.
  - 010 and all other codes: word.
- Misalignment:
  - MISALIGNED = req & ((half & ADDR[0]) | (word & (ADDR[1:0]!=0))).
  - A misaligned request issues no memory access and no stall, and leaves LOAD_DATA unchanged.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If req & !MISALIGNED: MEM_BUSYWAIT=1 combinationally in this same cycle.
  - At the next edge: capture FUNC3 and ADDR[1:0], drive DMEM_* outputs, go to ACCESS.
  - Otherwise stay in IDLE with MEM_BUSYWAIT=0.
- ACCESS:
  - MEM_BUSYWAIT=1.
  - When DMEM_BUSYWAIT=0 at an edge: latch extended data (reads only), drop DMEM_READ/DMEM_WRITE, go to DONE.
  - Otherwise increment the wait counter. If MAX_WAIT!=0 and the counter reaches MAX_WAIT: drop the strobes, set LOAD_DATA=0 and MEM_ERROR=1, go to DONE.
- DONE:
  - MEM_BUSYWAIT=0, so EX/MEM advances at this edge.
  - Go unconditionally to IDLE, clearing MEM_ERROR and the counter.
  - DONE never re-issues the request still present on the inputs.
- Latency: a load whose memory drops busywait in the first ACCESS cycle has request cycle t (IDLE), ACCESS t+1, DONE t+2. MEM_BUSYWAIT is high for 2 cycles and LOAD_DATA is valid from t+2 until the next load completes.
- Store lanes:
  - Byte: WRITEDATA = {4{WD[7:0]}}, BYTEEN = 4'b0001<<ADDR[1:0].
  - Half: WRITEDATA = {2{WD[15:0]}}, BYTEEN = ADDR[1] ? 4'b1100 : 4'b0011.
  - Word: WRITEDATA = WD, BYTEEN = 4'b1111.
- Reads: BYTEEN = 4'b1111.
- Load extract: byte/half selected by the captured offset from DMEM_READDATA. Signed codes sign-extend from bit 7 or 15; unsigned codes zero-extend.
- Back-to-back accesses: DONE → IDLE → next request. Minimum spacing is 3 cycles per access.
- DMEM_BUSYWAIT in IDLE or DONE is ignored.

Test Plan:
- Aligned LW: ADDR=0x100, FUNC3=010, memory busy 3 cycles, READDATA=0xDEADBEEF → DMEM_ADDR=0x100, BYTEEN=1111; MEM_BUSYWAIT high 5 cycles; LOAD_DATA=0xDEADBEEF in DONE.
- LB vs LBU: ADDR=0x103, READDATA=0x80AABBCC → LB gives 0xFFFFFF80, LBU gives 0x00000080; DMEM_ADDR=0x100.
- SB/SH lanes:
  - SB at 0x202, WD=0x123456A5 → WRITEDATA=0xA5A5A5A5, BYTEEN=0100.
  - SH at 0x202 → WRITEDATA=0x56A556A5, BYTEEN=1100.
- Misaligned: LW at 0x101, or LH at 0x203 → MISALIGNED=1, DMEM_READ stays 0, MEM_BUSYWAIT stays 0, LOAD_DATA unchanged.
- Timeout: MAX_WAIT=4, DMEM_BUSYWAIT stuck high → strobes drop after 4 ACCESS cycles; DONE with MEM_ERROR=1, LOAD_DATA=0; returns to IDLE.
- Reset mid-ACCESS: RESET=1 for one edge → next cycle state IDLE, DMEM_READ=0, MEM_BUSYWAIT=0, LOAD_DATA=0; a new LW then completes normally.
